prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Run-control state machine for the 9-bit accumulator core. It owns the program counter and the start/done handshake with the test harness. Each cycle it decides whether the instruction at `PC` executes: `InstEn` gates the register and memory write strobes that the instruction decoder produces. It advances `PC` from the decoder's `Branch`/`Halt` outputs and the branch-target lookup.

## Interface
- `PC_W`, 10, program-counter width; instruction ROM depth is 2^PC_W.
- `WATCHDOG`, 4096, maximum RUN cycles per program; 0 disables the watchdog.
- `Clk`  input  1  clock; all state changes on the rising edge.
- `Reset`  input  1  asynchronous, active-low reset.
- `Req`  input  1  start request from harness; level-sensitive.
- `StartAddr`  input  PC_W  first instruction address, sampled on start.
- `Branch`  input  1  taken-branch indication from the decoder (condition already applied).
- `Halt`  input  1  halt-opcode indication from the decoder.
- `BranchTarget`  input  PC_W  absolute target from the branch lookup table.
- `Stall`  input  1  datapath not ready; the current instruction must not retire.
- `PC`  output  PC_W  address of the instruction now executing.
- `InstEn`  output  1  current instruction retires this cycle.
- `Busy`  output  1  high in RUN.
- `Ack`  output  1  program finished; high in DONE.
- `Timeout`  output  1  last run ended by the watchdog, not by `Halt`.

## Operation
- States: IDLE, RUN, DONE. Encoding is in the package.
- IDLE:
  - `Req`=1 → RUN; `PC`<=`StartAddr`; watchdog count <= 0; `Timeout`<=0.
- RUN:
  - `InstEn` = !`Stall`.
  - `Stall`=1: `PC` holds, `Branch`/`Halt` are ignored, watchdog still counts.
  - `Stall`=0, `Halt`=1 → DONE; `PC` holds (stays on the halt instruction).
  - `Stall`=0, `Branch`=1 → `PC`<=`BranchTarget`.
  - `Stall`=0, otherwise → `PC`<=`PC`+1, modulo 2^PC_W (wraps to 0).
  - Watchdog: every RUN cycle increments the count. When `WATCHDOG`≠0, the count equals `WATCHDOG`-1, and `Halt` is not retiring this cycle: next state DONE and `Timeout`<=1. `PC` updates normally on that final cycle.
  - `Halt` beats watchdog in the same cycle: DONE with `Timeout`=0.
  - `Req` falling during RUN is ignored; the run completes.
- DONE:
  - `Ack`=1, held while `Req`=1.
  - `Req`=0 → IDLE.
  - `Req` must be seen low before a new run starts, so a level-held `Req` never restarts a program.
- Reset (any state, including mid-run): state IDLE, `PC`=0, count 0, `Timeout`=0. All outputs are 0 while reset is asserted and immediately after.
- Count register width: clog2(WATCHDOG+1), minimum 1.

## Timing
- All outputs are registered, except `InstEn`, which is combinational from state and `Stall`.
- Start: `Req` high at edge N → at N+1 `Busy`=1 and `PC`=`StartAddr`, so the first instruction executes in cycle N+1.
- Halt retiring in cycle M → at edge M+1 `Busy`=0 and `Ack`=1.
- `Req` low sampled in DONE at edge K → at K+1 `Ack`=0.
- Branch taken in cycle M → `PC`=`BranchTarget` from M+1; zero bubble.
- Minimum complete handshake (halt at `StartAddr`): Req↑ → Ack↑ in 2 edges.

## Configuration
- `PROG_SEQ_PERF_EN` defined:
  - Adds output `InstRetired` (16 bits): number of RUN cycles with `InstEn`=1, the halt included.
  - Cleared on entry to RUN, saturates at 16'hFFFF, held through DONE and IDLE until the next start.
  - Reset value 0.
- Not defined: no port, no counter logic; all other behaviour is identical.

## Structure
- `prog_seq_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - the `PC_W` default;
  - the `InstRetired` width constant (16).
- One sub-module, `pc_reg`: PC register with load/branch/increment/hold select. It is instantiated once; the FSM drives its select lines.

## Test plan
- Reset mid-run: assert `Reset` low in RUN with `PC`=0x05 → `PC`=0, `Busy`=0, `Ack`=0 immediately. After release, the sequencer waits in IDLE for `Req`.
- Straight-line: `StartAddr`=0x010, no branch, `Halt` at 0x014 → `PC` runs 0x010..0x014, `Ack` 1 cycle after. `InstRetired`=5 with `PROG_SEQ_PERF_EN`.
- Branch and stall: branch at 0x003 with target 0x200, `Stall` high for 2 cycles on 0x200 → `PC` sequence 3,0x200,0x200,0x200,0x201; `InstEn` low exactly on the 2 stalled cycles.
- Wrap: `StartAddr`=0x3FF, no halt there → next `PC`=0x000.
- Watchdog: `WATCHDOG`=8, infinite loop (branch to self) → DONE after 8 RUN cycles, `Timeout`=1. In a second run, `Halt` arrives in the 8th cycle → `Timeout`=0.
- Handshake: hold `Req` high through DONE → `Ack` stays 1 and no restart. Drop `Req` → IDLE next cycle. Raise `Req` → new run from the new `StartAddr`.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program run-control sequencer.
package prog_seq_pkg;

  localparam int unsigned PC_W_DEFAULT = 10;
  localparam int unsigned INST_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_LOAD   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_INC    = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: load start address, take branch, increment (wrapping) or hold.
module pc_reg
  import prog_seq_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_t         sel,
  input  logic [PC_W-1:0] load_addr,
  input  logic [PC_W-1:0] branch_addr,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else begin
      unique case (sel)
        PC_LOAD:   pc <= load_addr;
        PC_BRANCH: pc <= branch_addr;
        PC_INC:    pc <= pc + PC_W'(1);
        default:   pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Run-control FSM for the accumulator core: start/done handshake, PC sequencing, watchdog.
// Optional retired-instruction counter enabled by PROG_SEQ_PERF_EN.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEFAULT,
  parameter int unsigned WATCHDOG = 4096
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Req,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            Branch,
  input  logic            Halt,
  input  logic [PC_W-1:0] BranchTarget,
  input  logic            Stall,
  output logic [PC_W-1:0] PC,
  output logic            InstEn,
  output logic            Busy,
  output logic            Ack,
  output logic            Timeout
`ifdef PROG_SEQ_PERF_EN
  ,
  output logic [INST_CNT_W-1:0] InstRetired
`endif
);

  localparam int unsigned CW = (WATCHDOG < 2) ? 1 : $clog2(WATCHDOG + 1);
  localparam logic [CW-1:0] WD_LAST = CW'((WATCHDOG == 0) ? 0 : WATCHDOG - 1);

  seq_state_t    state, state_nxt;
  pc_sel_t       pc_sel;
  logic [CW-1:0] wd_cnt;
  logic          start;
  logic          wd_hit;

  pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk         (Clk),
    .rst_n       (Reset),
    .sel         (pc_sel),
    .load_addr   (StartAddr),
    .branch_addr (BranchTarget),
    .pc          (PC)
  );

  always_comb begin
    state_nxt = state;
    pc_sel    = PC_HOLD;
    InstEn    = 1'b0;
    start     = 1'b0;
    wd_hit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (Req) begin
          start     = 1'b1;
          pc_sel    = PC_LOAD;
          state_nxt = RUN;
        end
      end
      RUN: begin
        InstEn = !Stall;
        if (!Stall) begin
          if (Halt)        state_nxt = DONE;
          else if (Branch) pc_sel    = PC_BRANCH;
          else             pc_sel    = PC_INC;
        end
        // A retiring halt takes priority, so the watchdog only fires when no halt retires.
        if (WATCHDOG != 0 && wd_cnt == WD_LAST && !(InstEn && Halt)) begin
          wd_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!Req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      wd_cnt  <= '0;
      Timeout <= 1'b0;
      Busy    <= 1'b0;
      Ack     <= 1'b0;
    end else begin
      state <= state_nxt;
      Busy  <= (state_nxt == RUN);
      Ack   <= (state_nxt == DONE);
      if (start)             wd_cnt <= '0;
      else if (state == RUN) wd_cnt <= wd_cnt + CW'(1);
      if (start)       Timeout <= 1'b0;
      else if (wd_hit) Timeout <= 1'b1;
    end
  end

`ifdef PROG_SEQ_PERF_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      InstRetired <= '0;
    end else if (start) begin
      InstRetired <= '0;
    end else if (InstEn && InstRetired != '1) begin
      InstRetired <= InstRetired + INST_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed, table-driven bench for prog_sequencer (WATCHDOG reduced to 8).
module tb_prog_sequencer;
  import prog_seq_pkg::*;

  localparam int unsigned PC_W = 10;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            Req = 1'b0;
  logic [PC_W-1:0] StartAddr = '0;
  logic            Branch = 1'b0;
  logic            Halt = 1'b0;
  logic [PC_W-1:0] BranchTarget = '0;
  logic            Stall = 1'b0;
  logic [PC_W-1:0] PC;
  logic            InstEn, Busy, Ack, Timeout;
`ifdef PROG_SEQ_PERF_EN
  logic [INST_CNT_W-1:0] InstRetired;
`endif

  prog_sequencer #(.PC_W(PC_W), .WATCHDOG(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Req          (Req),
    .StartAddr    (StartAddr),
    .Branch       (Branch),
    .Halt         (Halt),
    .BranchTarget (BranchTarget),
    .Stall        (Stall),
    .PC           (PC),
    .InstEn       (InstEn),
    .Busy         (Busy),
    .Ack          (Ack),
    .Timeout      (Timeout)
`ifdef PROG_SEQ_PERF_EN
    ,
    .InstRetired  (InstRetired)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic            req;
    logic [PC_W-1:0] sa;
    logic            br;
    logic            ht;
    logic [PC_W-1:0] tg;
    logic            st;
    logic [PC_W-1:0] pc;
    logic            ie;
    logic            busy;
    logic            ack;
    logic            to;
  } vec_t;

  vec_t vecs[$];
  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic req, input logic [PC_W-1:0] sa, input logic br, input logic ht,
                     input logic [PC_W-1:0] tg, input logic st, input logic [PC_W-1:0] pc,
                     input logic ie, input logic busy, input logic ack, input logic to);
    vec_t v;
    v.req = req; v.sa = sa; v.br = br; v.ht = ht; v.tg = tg; v.st = st;
    v.pc = pc; v.ie = ie; v.busy = busy; v.ack = ack; v.to = to;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic req, input logic [PC_W-1:0] sa, input logic br,
                       input logic ht, input logic [PC_W-1:0] tg, input logic st);
    @(negedge Clk);
    Req = req; StartAddr = sa; Branch = br; Halt = ht; BranchTarget = tg; Stall = st;
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    check("reset_pc", 32'(PC), 32'h0);
    check("reset_busy", 32'(Busy), 32'h0);
    check("reset_ack", 32'(Ack), 32'h0);
    check("reset_instEn", 32'(InstEn), 32'h0);
    @(negedge Clk);
    Reset = 1'b1;

    // Reset mid-run at PC=0x005
    drive(1, 10'h005, 0, 0, 10'h0, 0);
    drive(0, 10'h000, 0, 0, 10'h0, 0);
    check("midrun_pc_before", 32'(PC), 32'h005);
    check("midrun_busy_before", 32'(Busy), 32'h1);
    Reset = 1'b0;
    #1;
    check("midrun_rst_pc", 32'(PC), 32'h0);
    check("midrun_rst_busy", 32'(Busy), 32'h0);
    check("midrun_rst_ack", 32'(Ack), 32'h0);
    check("midrun_rst_instEn", 32'(InstEn), 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    drive(0, 10'h000, 0, 0, 10'h0, 0);
    drive(0, 10'h000, 0, 0, 10'h0, 0);
    check("post_rst_idle_busy", 32'(Busy), 32'h0);
    check("post_rst_idle_pc", 32'(PC), 32'h0);

    //  req  sa      br ht tg      st | pc      ie busy ack to
    // straight-line 0x010..0x014, Req dropped mid-run, held through DONE
    add(1, 10'h010, 0, 0, 10'h000, 0,  10'h000, 0, 0, 0, 0);
    add(1, 10'h000, 0, 0, 10'h000, 0,  10'h010, 1, 1, 0, 0);
    add(0, 10'h000, 0, 0, 10'h000, 0,  10'h011, 1, 1, 0, 0);
    add(0, 10'h000, 0, 0, 10'h000, 0,  10'h012, 1, 1, 0, 0);
    add(0, 10'h000, 0, 0, 10'h000, 0,  10'h013, 1, 1, 0, 0);
    add(1, 10'h000, 0, 1, 10'h000, 0,  10'h014, 1, 1, 0, 0);
    add(1, 10'h155, 0, 0, 10'h000, 0,  10'h014, 0, 0, 1, 0);
    add(1, 10'h155, 0, 0, 10'h000, 0,  10'h014, 0, 0, 1, 0);
    add(0, 10'h000, 0, 0, 10'h000, 0,  10'h014, 0, 0, 1, 0);
    add(0, 10'h000, 0, 0, 10'h000, 0,  10'h014, 0, 0, 0, 0);
    // branch at 0x003 to 0x200, two stalls (branch/halt ignored while stalled)
    add(1, 10'h003, 0, 0, 10'h000, 0,  10'h014, 0, 0, 0, 0);
    add(0, 10'h000, 1, 0, 10'h200, 0,  10'h003, 1, 1, 0, 0);
    add(0, 10'h000, 1, 1, 10'h055, 1,  10'h200, 0, 1, 0, 0);
    add(0, 10'h000, 0, 0, 10'h000, 1,  10'h200, 0, 1, 0, 0);
    add(0, 10'h000, 0, 0, 10'h000, 0,  10'h200, 1, 1, 0, 0);
    add(0, 10'h000, 0, 1, 10'h000, 0,  10'h201, 1, 1, 0, 0);
    add(0, 10'h000, 0, 0, 10'h000, 0,  10'h201, 0, 0, 1, 0);
    // wrap from 0x3FF
    add(1, 10'h3FF, 0, 0, 10'h000, 0,  10'h201, 0, 0, 0, 0);
    add(1, 10'h000, 0, 0, 10'h000, 0,  10'h3FF, 1, 1, 0, 0);
    add(1, 10'h000, 0, 1, 10'h000, 0,  10'h000, 1, 1, 0, 0);
    add(1, 10'h000, 0, 0, 10'h000, 0,  10'h000, 0, 0, 1, 0);
    add(0, 10'h000, 0, 0, 10'h000, 0,  10'h000, 0, 0, 1, 0);
    add(0, 10'h000, 0, 0, 10'h000, 0,  10'h000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].sa, vecs[i].br, vecs[i].ht, vecs[i].tg, vecs[i].st);
      check($sformatf("v%0d_pc", i), 32'(PC), 32'(vecs[i].pc));
      check($sformatf("v%0d_instEn", i), 32'(InstEn), 32'(vecs[i].ie));
      check($sformatf("v%0d_busy", i), 32'(Busy), 32'(vecs[i].busy));
      check($sformatf("v%0d_ack", i), 32'(Ack), 32'(vecs[i].ack));
      check($sformatf("v%0d_timeout", i), 32'(Timeout), 32'(vecs[i].to));
`ifdef PROG_SEQ_PERF_EN
      if (i == 9)  check("retired_straight", 32'(InstRetired), 32'd5);
      if (i == 17) check("retired_branch", 32'(InstRetired), 32'd3);
`endif
    end

    // Watchdog: branch-to-self at 0x020, 8 RUN cycles then DONE with Timeout
    drive(1, 10'h020, 0, 0, 10'h000, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 10'h000, 1, 0, 10'h020, 0);
      check($sformatf("wd1_busy_c%0d", i + 1), 32'(Busy), 32'h1);
      check($sformatf("wd1_pc_c%0d", i + 1), 32'(PC), 32'h020);
    end
    drive(0, 10'h000, 0, 0, 10'h000, 0);
    check("wd1_busy_end", 32'(Busy), 32'h0);
    check("wd1_ack", 32'(Ack), 32'h1);
    check("wd1_timeout", 32'(Timeout), 32'h1);
    check("wd1_pc_final", 32'(PC), 32'h020);
    drive(0, 10'h000, 0, 0, 10'h000, 0);
    check("wd1_idle_ack", 32'(Ack), 32'h0);
    check("wd1_idle_timeout_held", 32'(Timeout), 32'h1);
`ifdef PROG_SEQ_PERF_EN
    check("retired_wd", 32'(InstRetired), 32'd8);
`endif

    // Second run: halt in the 8th cycle beats the watchdog
    drive(1, 10'h030, 0, 0, 10'h000, 0);
    for (int i = 0; i < 7; i++) begin
      drive(1, 10'h000, 1, 0, 10'h030, 0);
      if (i == 0) check("wd2_timeout_cleared", 32'(Timeout), 32'h0);
    end
    drive(1, 10'h000, 0, 1, 10'h000, 0);
    check("wd2_busy_c8", 32'(Busy), 32'h1);
    drive(1, 10'h000, 0, 0, 10'h000, 0);
    check("wd2_ack", 32'(Ack), 32'h1);
    check("wd2_timeout", 32'(Timeout), 32'h0);
    drive(1, 10'h000, 0, 0, 10'h000, 0);
    check("wd2_no_restart", 32'(Busy), 32'h0);
    drive(0, 10'h000, 0, 0, 10'h000, 0);
    drive(0, 10'h000, 0, 0, 10'h000, 0);
    check("wd2_idle_ack", 32'(Ack), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
